// File: rtl/mem_pkg.sv
// Shared memory constants and word type used by the RISC datapath and memory_block.
package mem_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 16;
  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned MEM_DEPTH_LOG2 = 10;

  typedef logic [15:0] word_t;

  localparam word_t MEM_RESET_VALUE = 16'h0000;

endpackage

// File: rtl/memory_reset_sync.sv
// Reset synchronizer (async assert, 2-flop sync de-assert) producing the memory enable.
// With MEMORY_RESET_CLEAR_EN defined it also sequences a word-by-word array clear.
module memory_reset_sync
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  en_c,
  output logic                  clr_we_c,
  output logic [DEPTH_LOG2-1:0] clr_idx_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

`ifdef MEMORY_RESET_CLEAR_EN
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  logic                  busy_q;
  logic                  busy_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] idx_d;

  // Clear walks index 0..LAST_IDX once the synchronizer releases; reset restarts it.
  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    if (sync_q[1] && busy_q) begin
      idx_d = idx_q + DEPTH_LOG2'(1);
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
    end
  end

  assign clr_we_c  = sync_q[1] & busy_q;
  assign en_c      = sync_q[1] & ~busy_q;
  assign clr_idx_o = idx_q;
`else
  assign en_c      = sync_q[1];
  assign clr_we_c  = 1'b0;
  assign clr_idx_o = '0;
`endif

endmodule

// File: rtl/memory_block.sv
// Single-port word-addressable memory: sync write, registered write-first read.
// Optional MEMORY_RESET_CLEAR_EN zeroes the array on reset.
module memory_block
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  WRITE,
  output logic [DATA_WIDTH-1:0] MEMOUT
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic                  en_c;
  logic                  clr_we_c;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] memout_q;
  logic [DATA_WIDTH-1:0] memout_d;

  memory_reset_sync #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_reset_sync (
    .clk      (CLK),
    .rst_n    (RST),
    .en_c     (en_c),
    .clr_we_c (clr_we_c),
    .clr_idx_o(clr_idx)
  );

  // Upper address bits alias modulo the implemented depth.
  assign idx_c = ADDR[DEPTH_LOG2-1:0];

  if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
  end

  // Array has no reset so it maps onto a RAM macro.
  always_ff @(posedge CLK) begin
    if (clr_we_c) begin
      mem_q[clr_idx] <= DATA_WIDTH'(MEM_RESET_VALUE);
    end else if (en_c && WRITE) begin
      mem_q[idx_c] <= DATA;
    end
  end

  always_comb begin
    memout_d = memout_q;
    if (en_c) begin
      memout_d = WRITE ? DATA : mem_q[idx_c];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      memout_q <= DATA_WIDTH'(MEM_RESET_VALUE);
    end else begin
      memout_q <= memout_d;
    end
  end

  assign MEMOUT = memout_q;

endmodule

// File: tb/tb_memory_block.sv
// Directed self-checking bench for memory_block.
module tb_memory_block;

  logic        CLK;
  logic        RST;
  logic [15:0] ADDR;
  logic [15:0] DATA;
  logic        WRITE;
  logic [15:0] MEMOUT;

  int checks;
  int errors;

  memory_block dut (
    .CLK   (CLK),
    .RST   (RST),
    .ADDR  (ADDR),
    .DATA  (DATA),
    .WRITE (WRITE),
    .MEMOUT(MEMOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (MEMOUT === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, MEMOUT, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we);
    @(negedge CLK);
    ADDR  = a;
    DATA  = d;
    WRITE = we;
    @(posedge CLK);
    #1;
  endtask

  // Release reset and walk through the synchronizer (and clear, when built in).
  task automatic release_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check({tag, "_sync1"}, 16'h0000);
    @(posedge CLK);
    #1;
    check({tag, "_sync2"}, 16'h0000);
`ifdef MEMORY_RESET_CLEAR_EN
    @(negedge CLK);
    WRITE = 1'b0;
    repeat (1024) @(posedge CLK);
    #1;
    check({tag, "_clear_hold"}, 16'h0000);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b0;
    ADDR   = 16'd300;
    DATA   = 16'd300;
    WRITE  = 1'b1;
    #1;
    check("reset_async", 16'h0000);

    // Write attempts while held in reset must not change MEMOUT.
    @(posedge CLK);
    #1;
    check("reset_edge1", 16'h0000);
    @(posedge CLK);
    #1;
    check("reset_edge2", 16'h0000);

    release_reset("rel1");
`ifdef MEMORY_RESET_CLEAR_EN
    step(16'd300, 16'd0, 1'b0);
    check("cleared_300", 16'h0000);
`endif

    step(16'd300, 16'd300, 1'b1);
    check("wr_first_300", 16'd300);
    step(16'd300, 16'd0, 1'b0);
    check("rd_300", 16'd300);

    step(16'd299, 16'd1, 1'b1);
    check("wr_first_299", 16'd1);
    step(16'd300, 16'd1, 1'b0);
    check("rd_300_undisturbed", 16'd300);
    step(16'd299, 16'd0, 1'b0);
    check("rd_299", 16'd1);

    // 1324 = 1024 + 300, so it aliases onto word 300.
    step(16'd1324, 16'hBEEF, 1'b1);
    check("wr_alias_1324", 16'hBEEF);
    step(16'd300, 16'd0, 1'b0);
    check("rd_alias_300", 16'hBEEF);

    step(16'd300, 16'd300, 1'b1);
    check("rewrite_300", 16'd300);

    // Reset falls between edges while a write is presented.
    @(negedge CLK);
    ADDR  = 16'd300;
    DATA  = 16'h1234;
    WRITE = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    check("midrun_async_clear", 16'h0000);
    @(posedge CLK);
    #1;
    check("midrun_edge", 16'h0000);

    release_reset("rel2");
    step(16'd300, 16'd0, 1'b0);
`ifdef MEMORY_RESET_CLEAR_EN
    check("midrun_no_write", 16'h0000);
`else
    check("midrun_no_write", 16'd300);
`endif

    step(16'd0, 16'hFFFF, 1'b1);
    check("b2b_wr0", 16'hFFFF);
    step(16'd1023, 16'h0001, 1'b1);
    check("b2b_wr1023", 16'h0001);
    step(16'd0, 16'h0000, 1'b0);
    check("b2b_rd0", 16'hFFFF);
    step(16'd1023, 16'h0000, 1'b0);
    check("b2b_rd1023", 16'h0001);
    step(16'd2047, 16'h0000, 1'b0);
    check("alias_rd2047", 16'h0001);
    step(16'hFC00, 16'h0000, 1'b0);
    check("alias_rdFC00", 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
